// File: rtl/mips_bus_pkg.sv
// Shared bus widths, reset vector and responder state encoding for the MIPS
// CPU bus and the slaves that sit on it.
package mips_bus_pkg;
  localparam int BUS_AW  = 32;
  localparam int BUS_DW  = 32;
  localparam int BUS_BEW = 4;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCEPT
  } bus_resp_state_t;
endpackage

// File: rtl/mips_bus_ram_decode.sv
// Combinational address decoder: maps a byte address onto the boot window
// (lower half of the RAM) or the data window (upper half).
module mips_bus_ram_decode
  import mips_bus_pkg::*;
#(
  parameter int          ADDR_WORDS_LOG2 = 12,
  parameter logic [31:0] BOOT_BASE       = RESET_VECTOR,
  parameter logic [31:0] DATA_BASE       = 32'h00001000
) (
  input  logic [BUS_AW-1:0]          address,
  output logic                       hit,
  output logic [ADDR_WORDS_LOG2-1:0] index
);
  localparam int          IW   = ADDR_WORDS_LOG2;
  localparam logic [31:0] SPAN = 32'd1 << (IW + 1);

  logic [31:0] boot_off;
  logic [31:0] data_off;

  // Offsets wrap as unsigned values; the span check happens on the full byte
  // offset so addresses below a base or past a window end never alias.
  assign boot_off = address - BOOT_BASE;
  assign data_off = address - DATA_BASE;

  always_comb begin
    hit   = 1'b0;
    index = '0;
    if (boot_off < SPAN) begin
      hit   = 1'b1;
      index = {1'b0, boot_off[IW:2]};
    end else if (data_off < SPAN) begin
      hit   = 1'b1;
      index = {1'b1, data_off[IW:2]};
    end
  end
endmodule

// File: rtl/mips_bus_ram_responder.sv
// Bus RAM slave with programmable wait states, byte-lane writes and a
// registered read port, mapped into a boot window and a data window.
module mips_bus_ram_responder
  import mips_bus_pkg::*;
#(
  parameter string       RAM_INIT_FILE   = "",
  parameter int          ADDR_WORDS_LOG2 = 12,
  parameter logic [31:0] BOOT_BASE       = RESET_VECTOR,
  parameter logic [31:0] DATA_BASE       = 32'h00001000,
  parameter int          WAIT_CYCLES     = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [BUS_AW-1:0]  address,
  input  logic               write,
  input  logic               read,
  output logic               waitrequest,
  input  logic [BUS_DW-1:0]  writedata,
  input  logic [BUS_BEW-1:0] byteenable,
  output logic [BUS_DW-1:0]  readdata
);
  localparam int         WORDS         = 1 << ADDR_WORDS_LOG2;
  localparam logic [3:0] WAIT_CNT_INIT = 4'(WAIT_CYCLES);

  // Handshake: a request (read or write) is held stable by the master while
  // waitrequest is high; it is accepted on the rising edge where waitrequest
  // is low, i.e. the edge that ends the ACCEPT cycle.
  bus_resp_state_t state, next_state;
  logic [3:0]      wait_cnt, next_cnt;

  logic                       req;
  logic                       accept;
  logic                       hit;
  logic [ADDR_WORDS_LOG2-1:0] index;
  logic [31:0]                mem [WORDS];

  assign req         = read | write;
  assign accept      = (state == ACCEPT) && req;
  assign waitrequest = req && (state != ACCEPT);

  mips_bus_ram_decode #(
    .ADDR_WORDS_LOG2 (ADDR_WORDS_LOG2),
    .BOOT_BASE       (BOOT_BASE),
    .DATA_BASE       (DATA_BASE)
  ) u_decode (
    .address (address),
    .hit     (hit),
    .index   (index)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = wait_cnt;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            next_state = ACCEPT;
          end else begin
            next_state = WAIT;
            next_cnt   = WAIT_CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else if (wait_cnt <= 4'd1) begin
          next_state = ACCEPT;
          next_cnt   = '0;
        end else begin
          next_cnt = wait_cnt - 4'd1;
        end
      end
      ACCEPT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Simultaneous read and write performs only the write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (accept && read && !write) begin
      readdata <= hit ? mem[index] : '0;
    end
  end

  always @(posedge clk) begin
    if (reset_n && accept && write && hit) begin
      for (int i = 0; i < BUS_BEW; i++) begin
        if (byteenable[i]) mem[index][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

  // Power-up memory image; contents survive reset.
  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = '0;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset_n) begin
      if (state == WAIT && !req)
        $error("mips_bus_ram_responder: request dropped during wait states");
      if (accept && read && write)
        $error("mips_bus_ram_responder: read and write asserted together");
      if (accept && address[1:0] != 2'b00)
        $warning("mips_bus_ram_responder: unaligned address %h", address);
    end
  end
`endif
endmodule

// File: tb/tb_mips_bus_ram_responder.sv
// Bench for mips_bus_ram_responder: three instances with 0, 3 and 5 wait
// states driven by a bus-master task, read results checked against exp_q.
module tb_mips_bus_ram_responder;
  import mips_bus_pkg::*;

  localparam logic [31:0] BOOT = 32'hBFC00000;
  localparam logic [31:0] DATA = 32'h00001000;

  logic        clk = 1'b0;
  logic        rst_n       [3];
  logic [31:0] address     [3];
  logic        write       [3];
  logic        read        [3];
  logic        waitrequest [3];
  logic [31:0] writedata   [3];
  logic [3:0]  byteenable  [3];
  logic [31:0] readdata    [3];

  logic [31:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_bus_ram_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset_n(rst_n[0]), .address(address[0]), .write(write[0]),
    .read(read[0]), .waitrequest(waitrequest[0]), .writedata(writedata[0]),
    .byteenable(byteenable[0]), .readdata(readdata[0]));

  mips_bus_ram_responder #(.WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .reset_n(rst_n[1]), .address(address[1]), .write(write[1]),
    .read(read[1]), .waitrequest(waitrequest[1]), .writedata(writedata[1]),
    .byteenable(byteenable[1]), .readdata(readdata[1]));

  mips_bus_ram_responder #(.WAIT_CYCLES(5)) u_dut2 (
    .clk(clk), .reset_n(rst_n[2]), .address(address[2]), .write(write[2]),
    .read(read[2]), .waitrequest(waitrequest[2]), .writedata(writedata[2]),
    .byteenable(byteenable[2]), .readdata(readdata[2]));

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be, input bit hold,
                      output int waits, output logic [31:0] rd);
    waits = 0;
    address[d] = a; write[d] = wr; read[d] = ~wr; writedata[d] = wd; byteenable[d] = be;
    #1;
    while (waitrequest[d] !== 1'b0 && waits < 64) begin
      waits++;
      @(negedge clk); #1;
    end
    if (waits >= 64) begin
      n_cmp++; n_err++;
      $display("FAIL timeout dut%0d addr %h: waitrequest still %b, required 0", d, a, waitrequest[d]);
    end
    @(negedge clk);
    rd = readdata[d];
    if (!hold) begin read[d] = 1'b0; write[d] = 1'b0; end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; read[d] = 1'b0; write[d] = 1'b0;
      address[d] = '0; writedata[d] = '0; byteenable[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (readdata[d] !== 32'h0) begin
        n_err++; $display("FAIL reset_readdata dut%0d: got %h required 00000000", d, readdata[d]);
      end
      n_cmp++;
      if (waitrequest[d] !== 1'b0) begin
        n_err++; $display("FAIL reset_waitrequest dut%0d: got %b required 0", d, waitrequest[d]);
      end
      rst_n[d] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_boot_read();
    int w; logic [31:0] rd;
    xfer(0, 1'b1, BOOT + 32'h28, 32'h00AA0000, 4'hF, 1'b0, w, rd);
    exp_q.push_back(32'h00AA0000);
    xfer(0, 1'b0, BOOT + 32'h28, 32'h0, 4'h0, 1'b0, w, rd);
    n_cmp++;
    if (w != 1) begin n_err++; $display("FAIL boot_read_waits: got %0d required 1", w); end
    n_cmp++;
    if (rd !== exp_q[0]) begin n_err++; $display("FAIL boot_read_data: got %h required %h", rd, exp_q[0]); end
    // readdata must hold across a following write
    xfer(0, 1'b1, DATA + 32'h40, 32'h12345678, 4'hF, 1'b0, w, rd);
    n_cmp++;
    if (rd !== exp_q.pop_front()) begin n_err++; $display("FAIL readdata_hold: got %h required 00AA0000", rd); end
  endtask

  task automatic test_partial_write();
    int w; logic [31:0] rd, a, init, wd, e; logic [3:0] be;
    xfer(0, 1'b1, DATA, 32'h11223344, 4'hF, 1'b0, w, rd);
    xfer(0, 1'b1, DATA, 32'hAABBCCDD, 4'b0101, 1'b0, w, rd);
    exp_q.push_back(32'h11BB33DD);
    xfer(0, 1'b0, DATA, 32'h0, 4'h0, 1'b0, w, rd);
    n_cmp++;
    if (rd !== exp_q.pop_front()) begin n_err++; $display("FAIL partial_write: got %h required 11BB33DD", rd); end
    for (int k = 0; k < 6; k++) begin
      a = DATA + 32'($urandom_range(1, 2047)) * 4;
      init = $urandom; wd = $urandom; be = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) e[8*i +: 8] = be[i] ? wd[8*i +: 8] : init[8*i +: 8];
      xfer(0, 1'b1, a, init, 4'hF, 1'b0, w, rd);
      xfer(0, 1'b1, a, wd, be, 1'b0, w, rd);
      exp_q.push_back(e);
      xfer(0, 1'b0, a, 32'h0, 4'h0, 1'b0, w, rd);
      e = exp_q.pop_front();
      n_cmp++;
      if (rd !== e) begin n_err++; $display("FAIL lanes_%0d addr %h be %b: got %h required %h", k, a, be, rd, e); end
    end
  endtask

  task automatic test_boundaries();
    int w; logic [31:0] rd, e;
    logic [31:0] ba [7] = '{32'hBFC01FFC, 32'h00001000, 32'h00002FFC, 32'hBFC02000,
                            32'h00003000, 32'h80000000, 32'h00000FFC};
    logic [31:0] bd [7] = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4,
                            32'hE5E5E5E5, 32'hDEADBEEF, 32'hF6F6F6F6};
    bit mapped [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) xfer(0, 1'b1, ba[i], bd[i], 4'hF, 1'b0, w, rd);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(mapped[i] ? bd[i] : 32'h0);
      xfer(0, 1'b0, ba[i], 32'h0, 4'h0, 1'b0, w, rd);
      e = exp_q.pop_front();
      n_cmp++;
      if (rd !== e) begin n_err++; $display("FAIL window_%h: got %h required %h", ba[i], rd, e); end
      n_cmp++;
      if (w != 1) begin n_err++; $display("FAIL window_waits_%h: got %0d required 1", ba[i], w); end
    end
    exp_q.push_back(32'h00AA0000);
    exp_q.push_back(32'h0);
    xfer(0, 1'b0, BOOT + 32'h28, 32'h0, 4'h0, 1'b0, w, rd);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e) begin n_err++; $display("FAIL boot_word10_kept: got %h required %h", rd, e); end
    xfer(0, 1'b0, BOOT, 32'h0, 4'h0, 1'b0, w, rd);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e) begin n_err++; $display("FAIL boot_word0_kept: got %h required %h", rd, e); end
  endtask

  task automatic test_back_to_back();
    int w; logic [31:0] rd, e;
    logic [31:0] val [2] = '{32'h0BADF00D, 32'h600DCAFE};
    for (int i = 0; i < 2; i++) begin
      xfer(1, 1'b1, BOOT + 32'(i * 4), val[i], 4'hF, 1'b0, w, rd);
      n_cmp++;
      if (w != 4) begin n_err++; $display("FAIL wait3_write_%0d: got %0d required 4", i, w); end
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(val[i]);
      xfer(1, 1'b0, BOOT + 32'(i * 4), 32'h0, 4'h0, (i == 0), w, rd);
      e = exp_q.pop_front();
      n_cmp++;
      if (w != 4) begin n_err++; $display("FAIL b2b_waits_%0d: got %0d required 4", i, w); end
      n_cmp++;
      if (rd !== e) begin n_err++; $display("FAIL b2b_data_%0d: got %h required %h", i, rd, e); end
    end
  endtask

  task automatic test_reset_mid();
    int w; logic [31:0] rd, e;
    xfer(2, 1'b1, DATA + 32'h10, 32'h5A5A1234, 4'hF, 1'b0, w, rd);
    n_cmp++;
    if (w != 6) begin n_err++; $display("FAIL wait5_waits: got %0d required 6", w); end
    xfer(2, 1'b0, DATA + 32'h10, 32'h0, 4'h0, 1'b0, w, rd);
    address[2] = DATA + 32'h10; writedata[2] = 32'hFFFFFFFF; byteenable[2] = 4'hF; write[2] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (readdata[2] !== 32'h0) begin n_err++; $display("FAIL midreset_readdata: got %h required 00000000", readdata[2]); end
    n_cmp++;
    if (u_dut2.state !== IDLE) begin n_err++; $display("FAIL midreset_state: got %0d required %0d", u_dut2.state, IDLE); end
    write[2] = 1'b0;
    rst_n[2] = 1'b1;
    @(negedge clk);
    exp_q.push_back(32'h5A5A1234);
    xfer(2, 1'b0, DATA + 32'h10, 32'h0, 4'h0, 1'b0, w, rd);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e) begin n_err++; $display("FAIL midreset_word_kept: got %h required %h", rd, e); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_boot_read();
    test_partial_write();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
